// File: rtl/rs_alloc_if.sv
// rs_alloc_if: dispatch, wakeup and issue-grant signals of the reservation-station allocator.
interface rs_alloc_if #(parameter int N_ENTRY = 4, parameter int TAG_W = 4);
  logic               disp_valid_i;
  logic               disp_ready_o;
  logic [TAG_W-1:0]   disp_dest_i;
  logic [TAG_W-1:0]   disp_src1_i;
  logic [TAG_W-1:0]   disp_src2_i;
  logic               disp_src1_rdy_i;
  logic               disp_src2_rdy_i;
  logic               cdb_valid_i;
  logic [TAG_W-1:0]   cdb_tag_i;
  logic               allocate_o;
  logic [N_ENTRY-1:0] entry_free_o;
  logic [N_ENTRY-1:0] entry_ready_o;
  logic [N_ENTRY-1:0] entry_sel_i;
  logic               issue_valid_o;
  logic [TAG_W-1:0]   issue_dest_o;
  modport master (
    output disp_valid_i, disp_dest_i, disp_src1_i, disp_src2_i, disp_src1_rdy_i, disp_src2_rdy_i,
           cdb_valid_i, cdb_tag_i, entry_sel_i,
    input  disp_ready_o, allocate_o, entry_free_o, entry_ready_o, issue_valid_o, issue_dest_o
  );
  modport slave (
    input  disp_valid_i, disp_dest_i, disp_src1_i, disp_src2_i, disp_src1_rdy_i, disp_src2_rdy_i,
           cdb_valid_i, cdb_tag_i, entry_sel_i,
    output disp_ready_o, allocate_o, entry_free_o, entry_ready_o, issue_valid_o, issue_dest_o
  );
endinterface

// File: rtl/rs_alloc.sv
// rs_alloc: reservation-station entry allocator with CDB wakeup and grant-driven release.
module rs_alloc #(
  parameter int N_ENTRY = 4,
  parameter int TAG_W   = 4
) (
  input logic     clk_i,
  input logic     reset_i,
  rs_alloc_if.slave bus
);
  logic [N_ENTRY-1:0] r_free, r_rdy1, r_rdy2;
  logic [TAG_W-1:0]   r_dest [N_ENTRY];
  logic [TAG_W-1:0]   r_src1 [N_ENTRY];
  logic [TAG_W-1:0]   r_src2 [N_ENTRY];
  logic [N_ENTRY-1:0] w_ready, w_sel, w_rel, w_alloc;
  logic               w_byp1, w_byp2;
  // Allocation target comes from the registered free mask only, so an entry
  // released this cycle cannot be reallocated until the next one.
  always_comb begin
    w_ready            = ~r_free & r_rdy1 & r_rdy2;
    w_sel              = bus.entry_sel_i & (~bus.entry_sel_i + N_ENTRY'(1));
    w_rel              = w_sel & w_ready;
    bus.disp_ready_o   = |r_free;
    bus.allocate_o     = bus.disp_valid_i & bus.disp_ready_o;
    w_alloc            = bus.allocate_o ? (r_free & (~r_free + N_ENTRY'(1))) : '0;
    w_byp1             = bus.cdb_valid_i && (bus.disp_src1_i == bus.cdb_tag_i);
    w_byp2             = bus.cdb_valid_i && (bus.disp_src2_i == bus.cdb_tag_i);
    bus.entry_free_o   = r_free;
    bus.entry_ready_o  = w_ready;
    bus.issue_valid_o  = |w_rel;
    bus.issue_dest_o   = '0;
    for (int i = 0; i < N_ENTRY; i++)
      bus.issue_dest_o = bus.issue_dest_o | (w_rel[i] ? r_dest[i] : '0);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_free <= '1;
      r_rdy1 <= '0;
      r_rdy2 <= '0;
      for (int i = 0; i < N_ENTRY; i++) begin
        r_dest[i] <= '0;
        r_src1[i] <= '0;
        r_src2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ENTRY; i++) begin
        if (w_alloc[i]) begin
          r_free[i] <= 1'b0;
          r_dest[i] <= bus.disp_dest_i;
          r_src1[i] <= bus.disp_src1_i;
          r_src2[i] <= bus.disp_src2_i;
          r_rdy1[i] <= bus.disp_src1_rdy_i | w_byp1;
          r_rdy2[i] <= bus.disp_src2_rdy_i | w_byp2;
        end else if (w_rel[i]) begin
          r_free[i] <= 1'b1;
          r_rdy1[i] <= 1'b0;
          r_rdy2[i] <= 1'b0;
        end else if (!r_free[i] && bus.cdb_valid_i) begin
          if (r_src1[i] == bus.cdb_tag_i) r_rdy1[i] <= 1'b1;
          if (r_src2[i] == bus.cdb_tag_i) r_rdy2[i] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/rs_alloc.md
RS_ALLOC -- requirements
Module: rs_alloc

Interface
REQ-001 Parameter: N_ENTRY, default 4, number of reservation-station entries; the issue-select vectors are N_ENTRY bits wide.
REQ-002 Parameter: TAG_W, default 4, physical tag width.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 disp_valid_i  input  1  dispatch request carries a valid instruction.
REQ-006 disp_ready_o  output  1  a free entry exists; the dispatch is accepted when valid and ready are both high.
REQ-007 disp_dest_i  input  TAG_W  destination tag.
REQ-008 disp_src1_i, disp_src2_i  input  TAG_W each  source tags.
REQ-009 disp_src1_rdy_i, disp_src2_rdy_i  input  1 each  source already available at dispatch.
REQ-010 cdb_valid_i  input  1  a result broadcast is present.
REQ-011 cdb_tag_i  input  TAG_W  tag of the broadcast result.
REQ-012 allocate_o  output  1  pulse, high in the cycle a dispatch is accepted; feeds the issue selector allocate input.
REQ-013 entry_free_o  output  N_ENTRY  registered free mask, bit i=1 means entry i is empty; feeds the selector resource_valid input.
REQ-014 entry_ready_o  output  N_ENTRY  entry i is occupied and both of its sources are ready.
REQ-015 entry_sel_i  input  N_ENTRY  one-hot or zero issue grant from the selector.
REQ-016 issue_valid_o  output  1  entry_sel_i names an occupied, ready entry.
REQ-017 issue_dest_o  output  TAG_W  destination tag of the granted entry; 0 when issue_valid_o is 0.

Function
REQ-018 disp_ready_o shall equal the OR of the registered entry_free_o, with no combinational path from entry_sel_i.
REQ-019 On an accepted dispatch, the target entry shall be the lowest-index bit set in entry_free_o.
REQ-020 Allocation write (next edge): the target entry's free bit is cleared and dest, src1, src2 and the two ready flags are stored.
REQ-021 allocate_o shall be combinational: disp_valid_i AND disp_ready_o.
REQ-022 Release: if entry_sel_i[i] is set and entry i is occupied and ready, entry i's free bit shall be set at the next edge and its ready flags cleared.
REQ-023 A grant to an entry that is free or not ready shall be ignored, leaving no state change and issue_valid_o=0.
REQ-024 A grant with more than one bit set is illegal; the block shall act on the lowest set bit only.
REQ-025 Wakeup: when cdb_valid_i is high, every occupied entry whose src1 or src2 tag equals cdb_tag_i shall set the matching ready flag at the next edge.
REQ-026 Dispatch/CDB bypass: if an accepted dispatch has a src tag equal to cdb_tag_i while cdb_valid_i is high, that src shall be stored ready.
REQ-027 entry_ready_o[i] shall be taken combinationally from registered state only (occupied AND src1_rdy AND src2_rdy); a wakeup becomes visible one cycle after the CDB.
REQ-028 Simultaneous release and dispatch: the entry being released shall not be reallocated in the same cycle; it becomes eligible the next cycle.
REQ-029 Full condition: with all entries occupied, disp_ready_o=0 and allocate_o=0 regardless of disp_valid_i, and no state change occurs from dispatch.
REQ-030 issue_dest_o and issue_valid_o shall be combinational from entry_sel_i and the registered state, giving zero-cycle latency from grant.

Reset
REQ-031 In any cycle with reset_i high at the edge, all entries shall become free and all ready flags and tags shall be cleared; reset overrides dispatch, wakeup and release.
REQ-032 Values after reset: entry_free_o = all ones, entry_ready_o = 0, disp_ready_o = 1, issue_valid_o = 0, issue_dest_o = 0.
REQ-033 Values during reset: allocate_o shall still follow REQ-021, but no allocation shall take effect.

Verification
REQ-034 Reset, then dispatch dest=5 src1=2 (rdy=1) src2=3 (rdy=1) -> same-cycle allocate_o=1; next cycle entry_free_o=1110 and entry_ready_o=0001.
REQ-035 Dispatch dest=6 src1=7 (rdy=0) src2=3 (rdy=1) into entry 1, then CDB tag=7 -> entry_ready_o[1] stays 0 in the CDB cycle and becomes 1 the cycle after.
REQ-036 Entries 0 and 1 ready with dest 5 and 6, entry_sel_i=0001 -> issue_valid_o=1 and issue_dest_o=5 in the same cycle; next cycle entry_free_o=1101.
REQ-037 Fill all 4 entries, then hold disp_valid_i=1 -> disp_ready_o=0 and allocate_o=0; grant entry 2 -> disp_ready_o=1 the next cycle and the following dispatch lands in entry 2.
REQ-038 Dispatch src1=9 (rdy=0) in the same cycle as CDB tag=9 -> entry stored with src1 ready; grant to a not-ready entry -> issue_valid_o=0 and no state change.
REQ-039 Assert reset_i mid-operation with 3 entries occupied -> next cycle entry_free_o=1111 and entry_ready_o=0000.
